// File: rtl/write_back_regfile_scoreboard_pkg.sv
// rtl/write_back_regfile_scoreboard_pkg.sv - shared constants for the write-back register file and scoreboard
package write_back_regfile_scoreboard_pkg;
  localparam int NUM_REGS = 16;
  localparam int NUM_GPR = NUM_REGS - 1;
  localparam logic [3:0] PC_IDX = 4'd15;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;
endpackage

// File: rtl/write_back_regfile_scoreboard_if.sv
// rtl/write_back_regfile_scoreboard_if.sv - MEM/WB, decode-read and scoreboard signal bundle
interface write_back_regfile_scoreboard_if #(
  parameter int W = 32
);
  logic         PCSrcW;
  logic         RegWriteW;
  logic         MemtoRegW;
  logic [W-1:0] RDW;
  logic [W-1:0] AluResultW;
  logic [3:0]   WA3W;
  logic [W-1:0] ResultW;
  logic [3:0]   RA1D;
  logic [3:0]   RA2D;
  logic [W-1:0] PCPlus8D;
  logic [W-1:0] RD1D;
  logic [W-1:0] RD2D;
  logic         IssueD;
  logic         IssueRegWriteD;
  logic [3:0]   IssueWA3D;
  logic         KillValid;
  logic [3:0]   KillWA3;
  logic         StallD;
  logic         ScoreErr;

  modport master (
    output PCSrcW, RegWriteW, MemtoRegW, RDW, AluResultW, WA3W,
    output RA1D, RA2D, PCPlus8D, IssueD, IssueRegWriteD, IssueWA3D,
    output KillValid, KillWA3,
    input  ResultW, RD1D, RD2D, StallD, ScoreErr
  );

  modport slave (
    input  PCSrcW, RegWriteW, MemtoRegW, RDW, AluResultW, WA3W,
    input  RA1D, RA2D, PCPlus8D, IssueD, IssueRegWriteD, IssueWA3D,
    input  KillValid, KillWA3,
    output ResultW, RD1D, RD2D, StallD, ScoreErr
  );
endinterface

// File: rtl/write_back_regfile_scoreboard_counter.sv
// rtl/write_back_regfile_scoreboard_counter.sv - in-flight writer counter for one register
module write_back_regfile_scoreboard_counter
  import write_back_regfile_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             err
);
  localparam logic [CNT_W+1:0] MAX_WIDE = (CNT_W + 2)'(CNT_MAX);

  logic [CNT_W+1:0] sum;
  logic             under;
  logic             over;
  logic [CNT_W-1:0] count_next;

  // Two guard bits: the top bit flags a negative result after wrap-around.
  always_comb begin
    sum = {2'b00, count} + {{(CNT_W + 1){1'b0}}, inc}
        - {{(CNT_W + 1){1'b0}}, dec_a} - {{(CNT_W + 1){1'b0}}, dec_b};
    under = sum[CNT_W+1];
    over = !under && (sum > MAX_WIDE);
    count_next = sum[CNT_W-1:0];
    if (under) begin
      count_next = '0;
    end else if (over) begin
      count_next = count;
    end
  end

  assign err = under || over;
  assign busy = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end
endmodule

// File: rtl/write_back_regfile_scoreboard.sv
// rtl/write_back_regfile_scoreboard.sv - write-back select, R0..R14 commit, bypassed decode reads, RAW scoreboard
module write_back_regfile_scoreboard
  import write_back_regfile_scoreboard_pkg::*;
#(
  parameter int W = 32
) (
  input logic                           clk,
  input logic                           reset_asynchronous_n,
  write_back_regfile_scoreboard_if.slave bus
);
  logic [W-1:0]     regs [NUM_GPR];
  logic [W-1:0]     result;
  logic             commit;
  logic             stall;
  logic             score_err;
  logic [NUM_GPR-1:0] inc;
  logic [NUM_GPR-1:0] dec_a;
  logic [NUM_GPR-1:0] dec_b;
  logic [NUM_GPR-1:0] busy;
  logic [NUM_GPR-1:0] err;
  logic [CNT_W-1:0] cnt [NUM_GPR];

  assign result = bus.MemtoRegW ? bus.RDW : bus.AluResultW;
  assign commit = bus.RegWriteW && !bus.PCSrcW && (bus.WA3W != PC_IDX);
  assign bus.ResultW = result;

  always_comb begin
    bus.RD1D = regs[bus.RA1D];
    if (bus.RA1D == PC_IDX) begin
      bus.RD1D = bus.PCPlus8D;
    end else if (commit && bus.RA1D == bus.WA3W) begin
      bus.RD1D = result;
    end
  end

  always_comb begin
    bus.RD2D = regs[bus.RA2D];
    if (bus.RA2D == PC_IDX) begin
      bus.RD2D = bus.PCPlus8D;
    end else if (commit && bus.RA2D == bus.WA3W) begin
      bus.RD2D = result;
    end
  end

  // A last outstanding writer retiring this cycle is covered by the bypass, so it does not stall.
  always_comb begin
    stall = 1'b0;
    if (bus.RA1D != PC_IDX && busy[bus.RA1D]
        && !(dec_a[bus.RA1D] && cnt[bus.RA1D] == CNT_W'(1))) begin
      stall = 1'b1;
    end
    if (bus.RA2D != PC_IDX && busy[bus.RA2D]
        && !(dec_a[bus.RA2D] && cnt[bus.RA2D] == CNT_W'(1))) begin
      stall = 1'b1;
    end
  end
  assign bus.StallD = stall;

  for (genvar r = 0; r < NUM_GPR; r++) begin : g_cnt
    assign inc[r] = bus.IssueD && !stall && bus.IssueRegWriteD && (bus.IssueWA3D == 4'(r));
    assign dec_a[r] = bus.RegWriteW && (bus.WA3W == 4'(r));
    assign dec_b[r] = bus.KillValid && (bus.KillWA3 == 4'(r));

    write_back_regfile_scoreboard_counter u_counter (
      .clk   (clk),
      .rst_n (reset_asynchronous_n),
      .inc   (inc[r]),
      .dec_a (dec_a[r]),
      .dec_b (dec_b[r]),
      .count (cnt[r]),
      .busy  (busy[r]),
      .err   (err[r])
    );
  end

  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      for (int r = 0; r < NUM_GPR; r++) begin
        regs[r] <= '0;
      end
    end else if (commit) begin
      regs[bus.WA3W] <= result;
    end
  end

  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      score_err <= 1'b0;
    end else begin
      score_err <= score_err | (|err);
    end
  end
  assign bus.ScoreErr = score_err;
endmodule

// File: tb/tb_write_back_regfile_scoreboard.sv
// tb/tb_write_back_regfile_scoreboard.sv - directed and random-traffic bench with a behavioural register/scoreboard model
module tb_write_back_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  write_back_regfile_scoreboard_if #(.W(32)) bus ();

  write_back_regfile_scoreboard #(.W(32)) dut (
    .clk                  (clk),
    .reset_asynchronous_n (rst_n),
    .bus                  (bus)
  );

  // Model: register contents and number of writers still in flight per register.
  logic [31:0] mreg [15];
  int          mcnt [15];
  bit          merr;

  function automatic logic [31:0] m_result();
    return bus.MemtoRegW ? bus.RDW : bus.AluResultW;
  endfunction

  function automatic bit m_commit();
    return bus.RegWriteW && !bus.PCSrcW && bus.WA3W != 4'd15;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] ra);
    if (ra == 4'd15) return bus.PCPlus8D;
    if (m_commit() && ra == bus.WA3W) return m_result();
    return mreg[ra];
  endfunction

  function automatic bit m_pending(input logic [3:0] ra);
    int eff;
    if (ra == 4'd15) return 1'b0;
    eff = mcnt[ra] - ((bus.RegWriteW && bus.WA3W == ra) ? 1 : 0);
    return eff > 0;
  endfunction

  function automatic bit m_stall();
    return m_pending(bus.RA1D) || m_pending(bus.RA2D);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int n;
    bit e;
    logic [31:0] res;
    bit st;
    if (!rst_n) begin
      for (int r = 0; r < 15; r++) begin
        mreg[r] <= '0;
        mcnt[r] <= 0;
      end
      merr <= 1'b0;
    end else begin
      res = m_result();
      st = m_stall();
      e = 1'b0;
      for (int r = 0; r < 15; r++) begin
        n = mcnt[r];
        if (bus.IssueD && !st && bus.IssueRegWriteD && bus.IssueWA3D == 4'(r)) n = n + 1;
        if (bus.RegWriteW && bus.WA3W == 4'(r)) n = n - 1;
        if (bus.KillValid && bus.KillWA3 == 4'(r)) n = n - 1;
        if (n < 0) begin
          n = 0;
          e = 1'b1;
        end else if (n > 3) begin
          n = 3;
          e = 1'b1;
        end
        mcnt[r] <= n;
      end
      merr <= merr | e;
      if (m_commit()) mreg[bus.WA3W] <= res;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_result", bus.ResultW, m_result());
    check("cmp_rd1", bus.RD1D, m_read(bus.RA1D));
    check("cmp_rd2", bus.RD2D, m_read(bus.RA2D));
    check("cmp_stall", 32'(bus.StallD), 32'(m_stall()));
    check("cmp_err", 32'(bus.ScoreErr), 32'(merr));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.PCSrcW = 0; bus.RegWriteW = 0; bus.MemtoRegW = 0;
    bus.RDW = '0; bus.AluResultW = '0; bus.WA3W = '0;
    bus.RA1D = '0; bus.RA2D = '0; bus.PCPlus8D = 32'h0000_1008;
    bus.IssueD = 0; bus.IssueRegWriteD = 0; bus.IssueWA3D = '0;
    bus.KillValid = 0; bus.KillWA3 = '0;
  endtask

  task automatic issue(input logic [3:0] wa);
    bus.IssueD = 1; bus.IssueRegWriteD = 1; bus.IssueWA3D = wa;
  endtask

  initial begin
    idle();
    bus.IssueD = 1; bus.IssueRegWriteD = 1; bus.IssueWA3D = 4'd4;
    bus.KillValid = 1; bus.KillWA3 = 4'd6; bus.MemtoRegW = 1;
    bus.RDW = 32'h1357_9BDF; bus.AluResultW = 32'h2468_ACE0; bus.WA3W = 4'd9;
    rst_n = 0;
    repeat (2) cyc();
    for (int i = 0; i < 15; i++) begin
      bus.RA1D = 4'(i);
      bus.RA2D = 4'(14 - i);
      #1;
      check("rst_rd1", bus.RD1D, 32'h0);
      check("rst_rd2", bus.RD2D, 32'h0);
      check("rst_stall", 32'(bus.StallD), 32'h0);
    end
    check("rst_err", 32'(bus.ScoreErr), 32'h0);
    bus.RA1D = 4'd15;
    #1 check("rst_pc8", bus.RD1D, 32'h0000_1008);
    cyc();
    idle();
    rst_n = 1;
    cyc();

    issue(4'd3); cyc(); idle();
    bus.RegWriteW = 1; bus.MemtoRegW = 1; bus.RDW = 32'hDEAD_BEEF;
    bus.AluResultW = 32'h1234_5678; bus.WA3W = 4'd3; bus.RA1D = 4'd3;
    #1;
    check("byp_result", bus.ResultW, 32'hDEAD_BEEF);
    check("byp_rd1", bus.RD1D, 32'hDEAD_BEEF);
    check("byp_stall", 32'(bus.StallD), 32'h0);
    cyc(); idle(); bus.RA1D = 4'd3;
    #1 check("commit_rd1", bus.RD1D, 32'hDEAD_BEEF);
    issue(4'd4); cyc(); idle();
    bus.RegWriteW = 1; bus.MemtoRegW = 0; bus.RDW = 32'h1111_1111;
    bus.AluResultW = 32'hCAFE_0004; bus.WA3W = 4'd4; bus.RA2D = 4'd4;
    #1;
    check("alu_result", bus.ResultW, 32'hCAFE_0004);
    check("alu_rd2", bus.RD2D, 32'hCAFE_0004);
    cyc(); idle();

    issue(4'd5); cyc(); idle(); bus.RA2D = 4'd5;
    #1 check("raw_stall0", 32'(bus.StallD), 32'h1);
    cyc();
    check("raw_stall1", 32'(bus.StallD), 32'h1);
    bus.RegWriteW = 1; bus.AluResultW = 32'h5555_5555; bus.WA3W = 4'd5;
    #1;
    check("wb_stall", 32'(bus.StallD), 32'h0);
    check("wb_rd2", bus.RD2D, 32'h5555_5555);
    cyc(); idle();

    issue(4'd7); cyc(); idle();
    issue(4'd7); bus.RegWriteW = 1; bus.WA3W = 4'd7;
    bus.AluResultW = 32'h7777_7777; bus.RA1D = 4'd7;
    #1 check("r7_same_stall", 32'(bus.StallD), 32'h0);
    cyc(); idle(); bus.RA1D = 4'd7;
    #1 check("r7_still_busy", 32'(bus.StallD), 32'h1);
    bus.RegWriteW = 1; bus.WA3W = 4'd7; bus.AluResultW = 32'h7777_0000;
    #1 check("r7_wb_stall", 32'(bus.StallD), 32'h0);
    cyc(); idle(); bus.RA1D = 4'd7;
    #1;
    check("r7_free", 32'(bus.StallD), 32'h0);
    check("r7_rd1", bus.RD1D, 32'h7777_0000);

    issue(4'd2);
    repeat (3) cyc();
    check("ovf_err_before", 32'(bus.ScoreErr), 32'h0);
    cyc(); idle();
    check("ovf_err_after", 32'(bus.ScoreErr), 32'h1);
    bus.RA1D = 4'd2; bus.KillValid = 1; bus.KillWA3 = 4'd2;
    #1 check("kill_keeps_stall", 32'(bus.StallD), 32'h1);
    repeat (3) cyc();
    idle(); bus.RA1D = 4'd2;
    #1 check("kill_drained", 32'(bus.StallD), 32'h0);
    bus.KillValid = 1; bus.KillWA3 = 4'd9;
    cyc(); idle(); bus.RA1D = 4'd9;
    #1;
    check("udf_stall", 32'(bus.StallD), 32'h0);
    check("udf_err", 32'(bus.ScoreErr), 32'h1);

    bus.PCSrcW = 1; bus.RegWriteW = 1; bus.WA3W = 4'd15; bus.MemtoRegW = 0;
    bus.AluResultW = 32'hAAAA_0000; bus.RA1D = 4'd15; bus.RA2D = 4'd3;
    bus.PCPlus8D = 32'h0000_2008;
    #1;
    check("pc_result", bus.ResultW, 32'hAAAA_0000);
    check("pc_rd1", bus.RD1D, 32'h0000_2008);
    check("pc_rd2", bus.RD2D, 32'hDEAD_BEEF);
    cyc(); idle(); bus.RA2D = 4'd3;
    #1 check("pc_no_commit", bus.RD2D, 32'hDEAD_BEEF);

    issue(4'd8); cyc(); idle(); bus.RA1D = 4'd3; bus.RA2D = 4'd8;
    #1 check("mid_busy", 32'(bus.StallD), 32'h1);
    #2 rst_n = 0;
    #1;
    check("mid_rd1", bus.RD1D, 32'h0);
    check("mid_stall", 32'(bus.StallD), 32'h0);
    check("mid_err", 32'(bus.ScoreErr), 32'h0);
    cyc();
    rst_n = 1;
    cyc();

    for (int k = 0; k < 300; k++) begin
      bus.PCSrcW = ($urandom_range(7) == 0);
      bus.RegWriteW = ($urandom_range(2) == 0);
      bus.MemtoRegW = $urandom_range(1);
      bus.RDW = $urandom; bus.AluResultW = $urandom;
      bus.WA3W = 4'($urandom_range(15));
      bus.RA1D = 4'($urandom_range(15)); bus.RA2D = 4'($urandom_range(15));
      bus.PCPlus8D = $urandom;
      bus.IssueD = ($urandom_range(1) == 0); bus.IssueRegWriteD = ($urandom_range(3) != 0);
      bus.IssueWA3D = 4'($urandom_range(15));
      bus.KillValid = ($urandom_range(7) == 0); bus.KillWA3 = 4'($urandom_range(15));
      cyc();
    end
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
